// File: rtl/inst_fetch_bridge_if.sv
// rtl/inst_fetch_bridge_if.sv - SRAM-like instruction bus between the fetch bridge and memory
interface inst_fetch_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_rdata,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_rdata,
    output inst_data_ok
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - IF-stage responder fetching the word pair at pc and pc+4
module inst_fetch_bridge #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc,
  input  logic                       if_cln,
  output logic [31:0]                if_inst,
  output logic [31:0]                if_inst_2,
  output logic                       delay_hard,
  output logic                       IADEE,
  inst_fetch_bridge_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WAIT_LO,
    S_REQ_HI,
    S_WAIT_HI
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_lo_q, buf_lo_d;
  logic [31:0] buf_hi_q, buf_hi_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        hit;
  logic        drop_now;

  // kseg0/kseg1 fold onto the low 512 MB; everything else is passed through
  function automatic logic [31:0] phys(input logic [31:0] va);
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  assign IADEE      = (pc[1:0] != 2'b00);
  assign hit        = buf_valid_q && (buf_pc_q == pc) && !IADEE;
  assign if_inst    = hit ? buf_lo_q : 32'h0;
  assign if_inst_2  = hit ? buf_hi_q : 32'h0;
  assign delay_hard = !hit && !IADEE && !if_cln;
  // a flush arriving together with a data beat discards that beat as well
  assign drop_now   = drop_q || if_cln;

  // state and buffer registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      buf_lo_q    <= 32'h0;
      buf_hi_q    <= 32'h0;
      buf_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      fetch_pc_q  <= 32'h0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_lo_q    <= buf_lo_d;
      buf_hi_q    <= buf_hi_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
    end
  end

  // fetch sequencing, bus request generation and buffer updates
  always_comb begin
    state_d       = state_q;
    buf_lo_d      = buf_lo_q;
    buf_hi_d      = buf_hi_q;
    buf_pc_d      = buf_pc_q;
    buf_valid_d   = buf_valid_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    bus.inst_req  = 1'b0;
    bus.inst_addr = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (!hit && !IADEE && !if_cln) begin
          fetch_pc_d  = pc;
          // buf_lo is about to be overwritten, so the old pair must stop hitting
          buf_valid_d = 1'b0;
          state_d     = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        bus.inst_req  = 1'b1;
        bus.inst_addr = phys(fetch_pc_q);
        if (if_cln) drop_d = 1'b1;
        if (bus.inst_addr_ok) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (bus.inst_data_ok) begin
          if (drop_now) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            buf_lo_d = bus.inst_rdata;
            state_d  = S_REQ_HI;
          end
        end else if (if_cln) begin
          drop_d = 1'b1;
        end
      end
      S_REQ_HI: begin
        bus.inst_req  = 1'b1;
        bus.inst_addr = phys(fetch_pc_q + 32'd4);
        if (if_cln) drop_d = 1'b1;
        if (bus.inst_addr_ok) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.inst_data_ok) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
          if (!drop_now) begin
            buf_hi_d    = bus.inst_rdata;
            buf_pc_d    = fetch_pc_q;
            buf_valid_d = 1'b1;
          end
        end else if (if_cln) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (if_cln) buf_valid_d = 1'b0;
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb/tb_inst_fetch_bridge.sv - scoreboard bench for inst_fetch_bridge
module tb_inst_fetch_bridge;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    int          stalls;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        if_cln;
  logic [31:0] if_inst, if_inst_2;
  logic        delay_hard, IADEE;

  inst_fetch_bridge_if bus ();

  inst_fetch_bridge #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .if_cln     (if_cln),
    .if_inst    (if_inst),
    .if_inst_2  (if_inst_2),
    .delay_hard (delay_hard),
    .IADEE      (IADEE),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int beats = 0;
  int lo_delay = 0;
  logic [31:0] addr_q[$];
  pair_t       pair_q[$];

  // memory model: word content is a fixed function of the physical address
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h1fc0_0000) return 32'h3c08_bfc0;
    if (a == 32'h1fc0_0004) return 32'h3508_0000;
    return a ^ 32'h5a5a_5a5a;
  endfunction

  logic [3:0]  wait_cnt;
  logic        pend_q;
  logic [31:0] pend_addr_q;

  assign bus.inst_addr_ok = bus.inst_req &&
                            (int'(wait_cnt) >= (bus.inst_addr[2] ? 0 : lo_delay));
  assign bus.inst_data_ok = pend_q;
  assign bus.inst_rdata   = pend_q ? memf(pend_addr_q) : 32'h0;

  always @(posedge clk) begin
    if (!reset) begin
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0;
      wait_cnt    <= 4'd0;
    end else begin
      pend_q      <= bus.inst_req && bus.inst_addr_ok;
      pend_addr_q <= bus.inst_addr;
      wait_cnt    <= (bus.inst_req && !bus.inst_addr_ok) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor state
  int          stall_cnt = 0;
  logic        prev_dh = 1'b1;
  logic        prev_req = 1'b0;
  logic        prev_aok = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (bus.inst_data_ok) beats++;
    if (bus.inst_req && bus.inst_addr_ok) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got addr %h expected none at %0t", bus.inst_addr, $time);
      end else begin
        chk("req_addr", bus.inst_addr, addr_q.pop_front());
      end
    end
    if (reset && prev_rst && prev_req && !prev_aok) begin
      chk("req_held", {31'h0, bus.inst_req}, 32'h1);
      chk("addr_held", bus.inst_addr, prev_addr);
    end
    if (reset && prev_dh && !delay_hard && !IADEE && !if_cln) begin
      if (pair_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_fill: got %h/%h expected none at %0t", if_inst, if_inst_2, $time);
      end else begin
        pair_t e;
        e = pair_q.pop_front();
        chk("if_inst", if_inst, e.i0);
        chk("if_inst_2", if_inst_2, e.i1);
        chk("stall_cycles", stall_cnt, e.stalls);
      end
    end
    stall_cnt = (reset && delay_hard) ? stall_cnt + 1 : 0;
    prev_dh   = delay_hard;
    prev_req  = bus.inst_req;
    prev_aok  = bus.inst_addr_ok;
    prev_addr = bus.inst_addr;
    prev_rst  = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input int s);
    pair_t p;
    p.i0 = a;
    p.i1 = b;
    p.stalls = s;
    pair_q.push_back(p);
  endtask

  task automatic drained(input string name);
    chk({name, "_addr_left"}, addr_q.size(), 0);
    chk({name, "_fill_left"}, pair_q.size(), 0);
  endtask

  initial begin
    int b0;
    reset  = 1'b0;
    pc     = 32'hbfc0_0000;
    if_cln = 1'b0;

    // reset state
    repeat (2) tick();
    at_neg();
    chk("rst_req", {31'h0, bus.inst_req}, 32'h0);
    chk("rst_addr", bus.inst_addr, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_inst2", if_inst_2, 32'h0);
    chk("rst_delay", {31'h0, delay_hard}, 32'h1);
    chk("rst_iadee", {31'h0, IADEE}, 32'h0);

    // boot fill, zero-wait memory
    addr_q.push_back(32'h1fc0_0000);
    addr_q.push_back(32'h1fc0_0004);
    push_pair(32'h3c08_bfc0, 32'h3508_0000, 5);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    drained("boot");

    // steady hit: no bus traffic, outputs stable
    repeat (6) begin
      at_neg();
      chk("hold_req", {31'h0, bus.inst_req}, 32'h0);
      chk("hold_inst", if_inst, 32'h3c08_bfc0);
      chk("hold_inst2", if_inst_2, 32'h3508_0000);
      chk("hold_delay", {31'h0, delay_hard}, 32'h0);
    end
    tick();

    // addr_ok delayed 3 cycles on the low request
    lo_delay = 3;
    pc = 32'h8000_0040;
    addr_q.push_back(32'h0000_0040);
    addr_q.push_back(32'h0000_0044);
    push_pair(32'h5a5a_5a1a, 32'h5a5a_5a1e, 8);
    repeat (12) tick();
    lo_delay = 0;
    drained("slow");

    // flush during WAIT_LO with a new pc
    b0 = beats;
    pc = 32'h8000_0200;
    addr_q.push_back(32'h0000_0200);
    addr_q.push_back(32'h0000_0100);
    addr_q.push_back(32'h0000_0104);
    push_pair(32'h5a5a_5b5a, 32'h5a5a_5b5e, 5);
    tick();
    tick();
    if_cln = 1'b1;
    pc = 32'h8000_0100;
    tick();
    if_cln = 1'b0;
    repeat (10) tick();
    chk("flush_beats", beats - b0, 3);
    drained("flush");

    // misaligned pc
    pc = 32'hbfc0_0002;
    repeat (4) begin
      at_neg();
      chk("ade_iadee", {31'h0, IADEE}, 32'h1);
      chk("ade_delay", {31'h0, delay_hard}, 32'h0);
      chk("ade_inst", if_inst, 32'h0);
      chk("ade_inst2", if_inst_2, 32'h0);
      chk("ade_req", {31'h0, bus.inst_req}, 32'h0);
    end
    tick();

    // reset while in REQ_HI, then full refetch
    pc = 32'hbfc0_0000;
    addr_q.push_back(32'h1fc0_0000);
    addr_q.push_back(32'h1fc0_0004);
    addr_q.push_back(32'h1fc0_0000);
    addr_q.push_back(32'h1fc0_0004);
    push_pair(32'h3c08_bfc0, 32'h3508_0000, 5);
    repeat (3) tick();
    reset = 1'b0;
    at_neg();
    chk("reqhi_req", {31'h0, bus.inst_req}, 32'h1);
    chk("reqhi_addr", bus.inst_addr, 32'h1fc0_0004);
    tick();
    reset = 1'b1;
    at_neg();
    chk("postrst_req", {31'h0, bus.inst_req}, 32'h0);
    chk("postrst_inst", if_inst, 32'h0);
    chk("postrst_delay", {31'h0, delay_hard}, 32'h1);
    repeat (10) tick();
    drained("rstfetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Instruction-side responder for the IF stage. Accepts the fetch address `pc` from IF, runs two sequential reads on the SRAM-like instruction bus: the word at `pc` and the word at `pc+4`. It returns the pair as `if_inst` and `if_inst_2` and holds IF with `delay_hard` until both words are valid. It sits between IF and the instruction memory/AXI bridge, and also raises the IF fetch address-error flag.

## Interface
Parameters:
- RESET_PC, 32'hbfc0_0000, initial fetch tag; no read is issued until `pc` is sampled.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
- pc  in  32  virtual fetch address driven by IF.
- if_cln  in  1  pipeline flush. Invalidates the buffer and drops the read in flight.
- if_inst  out  32  instruction at `pc`. Forced to 0 when not valid.
- if_inst_2  out  32  instruction at `pc+4`. Forced to 0 when not valid.
- delay_hard  out  1  stall request to IF. 1 means the words are not yet valid.
- IADEE  out  1  fetch address error: `pc[1:0]` is not 2'b00.
- inst_req  out  1  bus request.
- inst_addr  out  32  bus physical address.
- inst_addr_ok  in  1  request accepted.
- inst_rdata  in  32  read data.
- inst_data_ok  in  1  read data valid.

## Operation
Registers:
- `buf_lo`, `buf_hi`: the two instruction words.
- `buf_pc`: tag for the buffered pair.
- `buf_valid`: buffer holds a valid pair.
- `fetch_pc`: address of the current fetch.
- `drop`: discard the next data beat.
- `state`.

Hit and output rules:
- hit = `buf_valid` & (`buf_pc`==`pc`) & ~IADEE.
- `if_inst`=hit?`buf_lo`:0 and `if_inst_2`=hit?`buf_hi`:0. Combinational.
- `delay_hard` = ~hit & ~IADEE & ~`if_cln`. Combinational.
- IADEE = (`pc[1:0]`!=0). Combinational. No bus activity on an address error; `delay_hard`=0.

Address translation, applied to `inst_addr`:
- `pc[31:29]` = 3'b100 or 3'b101 maps to {3'b000, addr[28:0]}.
- All other addresses pass through unchanged.

FSM states and transitions:
- IDLE: a miss with ~IADEE and ~`if_cln` latches `fetch_pc`<=`pc` and moves to REQ_LO.
- REQ_LO: `inst_req`=1, `inst_addr`=phys(`fetch_pc`). `inst_addr_ok` moves to WAIT_LO.
- WAIT_LO: `inst_data_ok` captures `buf_lo` (unless `drop`) and moves to REQ_HI.
- REQ_HI: `inst_req`=1, `inst_addr`=phys(`fetch_pc`+4). `inst_addr_ok` moves to WAIT_HI.
- WAIT_HI: `inst_data_ok` captures `buf_hi` and sets `buf_pc`<=`fetch_pc`, `buf_valid`<=1 (unless `drop`), then moves to IDLE.

Request rules:
- `inst_req` is deasserted in IDLE and WAIT_*.
- Once asserted, `inst_req` and `inst_addr` are held stable until `inst_addr_ok`. A request is never withdrawn.
- At most one read is outstanding.

Flush (`if_cln`=1):
- Clears `buf_valid` in the same edge.
- In REQ_*: the handshake completes, then `drop` is set.
- In WAIT_*: `drop` is set.
- With `drop` set, the pending data beat is discarded. The FSM then goes to IDLE instead of REQ_HI, and `drop` clears.
- In IDLE: no fetch starts that cycle.

`pc` changes mid-fetch: the fetch completes with `fetch_pc` as tag. The next IDLE cycle sees a miss and refetches.

`inst_data_ok` in IDLE/REQ_*: ignored.

## Timing
Reset values (`reset`=0 at an edge):
- state=IDLE, `buf_valid`=0, `drop`=0, `buf_lo`=`buf_hi`=0, `buf_pc`=RESET_PC.
- Outputs: `inst_req`=0, `inst_addr`=0.
- With `buf_valid`=0: `if_inst`=`if_inst_2`=0. `delay_hard`=1 unless IADEE or `if_cln`.

Reset mid-fetch aborts immediately; the memory is reset by the same reset.

Miss latency with zero-wait memory (`addr_ok` same cycle as req, `data_ok` next cycle):
- cycle 0: miss seen in IDLE.
- cycle 1: REQ_LO.
- cycle 2: WAIT_LO.
- cycle 3: REQ_HI.
- cycle 4: WAIT_HI.
- cycle 5: hit, `delay_hard`=0, words valid.
- Total: 5 stall cycles.

Each extra wait cycle on `addr_ok` or `data_ok` adds one stall cycle. A hit has 0-cycle latency.

Simultaneous events:
- `if_cln` with the WAIT_HI `data_ok`: the beat is dropped and `buf_valid` stays 0.
- `if_cln` with a miss in IDLE: the flush wins.

## Test plan
- Reset, then `pc`=32'hbfc0_0000 with zero-wait memory holding 0x3c08bfc0/0x35080000 -> `inst_addr` 0x1fc0_0000 then 0x1fc0_0004. `delay_hard`=1 for cycles 0-4; at cycle 5 `if_inst`=0x3c08bfc0, `if_inst_2`=0x35080000, `delay_hard`=0.
- Hold `pc` constant after a fill -> no further `inst_req`; outputs are stable every cycle.
- `addr_ok` delayed 3 cycles on REQ_LO -> `inst_req`/`inst_addr` held constant for 4 cycles; stall lengthens by exactly 3.
- `if_cln` pulsed during WAIT_LO, new `pc`=0x8000_0100 -> stale beat discarded. Exactly one dropped `data_ok`, then a new fetch at phys 0x0000_0100/0x0000_0104; the old words never appear.
- `pc`=0xbfc0_0002 -> IADEE=1, `delay_hard`=0, `if_inst`=0, no `inst_req`.
- `reset` asserted in REQ_HI -> next cycle `inst_req`=0, state IDLE, `buf_valid`=0; the first post-reset miss refetches both words.
